sem_bit_arbiter: RTL and testbench

//  Arbitrates one single-port semaphore bit memory between three masters: the system-control image port (S), the bit CPU (0) and the word CPU (1).

---
 rtl/sem_bit_arbiter_pkg.sv | 39 +++
 rtl/sem_bit_arbiter_ram.sv | 27 ++
 rtl/sem_bit_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sem_bit_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sem_bit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sem_bit_arbiter_pkg
// Brief    : Shared encodings for the semaphore bit-memory arbiter.
// Revision : 1.0
// ============================================================================
package sem_bit_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GNT_S = 2'd0,
        GNT_0 = 2'd1,
        GNT_1 = 2'd2
    } gnt_e;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_TAS = 2'd2
    } op_e;

    // A write request dominates; the lock qualifier only matters on reads.
    function automatic op_e decode_op(input logic we, input logic lk);
        if (we) begin
            return OP_WR;
        end else if (lk) begin
            return OP_TAS;
        end
        return OP_RD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sem_bit_arbiter_ram.sv
`default_nettype none
// ============================================================================
// Module   : sem_bit_ram
// Brief    : Single-port 2**AW x 1 bit RAM, synchronous write and read.
// Revision : 1.0
// ============================================================================
module sem_bit_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic          i_d,
    output logic          o_q
);

    logic r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_d;
        end
        o_q <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/sem_bit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sem_bit_arbiter
// Brief    : Serialising arbiter (S > round-robin CPU0/CPU1) with atomic
//            test-and-set over a single-port semaphore bit RAM.
// Revision : 1.0
// ============================================================================
module sem_bit_arbiter
    import sem_bit_arbiter_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic [AW-1:0] A_S,
    input  logic          DI_S,
    input  logic          WE_S,
    input  logic          OE_S,
    output logic          DQ_S,
    output logic          WT_S,
    input  logic [AW-1:0] A_0,
    input  logic          DI_0,
    input  logic          WE_0,
    input  logic          OE_0,
    input  logic          LK_0,
    output logic          DQ_0,
    output logic          WT_0,
    input  logic [AW-1:0] A_1,
    input  logic          DI_1,
    input  logic          WE_1,
    input  logic          OE_1,
    input  logic          LK_1,
    output logic          DQ_1,
    output logic          WT_1,
    output logic          BUSY
);

    state_e        r_state;
    state_e        w_state_nx;
    gnt_e          r_gnt;
    gnt_e          w_win;
    op_e           r_op;
    op_e           w_win_op;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_win_addr;
    logic          r_di;
    logic          w_win_di;
    logic          r_last_cpu;
    logic          r_ack_s;
    logic          r_ack_0;
    logic          r_ack_1;
    logic          r_dq_s;
    logic          r_dq_0;
    logic          r_dq_1;
    logic          w_req_s;
    logic          w_req_0;
    logic          w_req_1;
    logic          w_any;
    logic          w_ram_we;
    logic          w_ram_d;
    logic          w_ram_q;
    logic          w_ack_set;
    logic          w_capture;

    assign w_req_s = WE_S | OE_S;
    assign w_req_0 = WE_0 | OE_0;
    assign w_req_1 = WE_1 | OE_1;
    assign w_any   = w_req_s | w_req_0 | w_req_1;

    // r_last_cpu: 0 = CPU0 granted last, 1 = CPU1 granted last.
    always_comb begin
        w_win      = GNT_S;
        w_win_addr = A_S;
        w_win_di   = DI_S;
        w_win_op   = decode_op(WE_S, 1'b0);
        if (w_req_s) begin
            w_win = GNT_S;
        end else if (w_req_0 && (!w_req_1 || r_last_cpu)) begin
            w_win      = GNT_0;
            w_win_addr = A_0;
            w_win_di   = DI_0;
            w_win_op   = decode_op(WE_0, LK_0);
        end else if (w_req_1) begin
            w_win      = GNT_1;
            w_win_addr = A_1;
            w_win_di   = DI_1;
            w_win_op   = decode_op(WE_1, LK_1);
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // TAS write-back happens in CAPTURE, so no grant can slip in between.
    always_comb begin
        w_state_nx = r_state;
        w_ram_we   = 1'b0;
        w_ram_d    = r_di;
        w_ack_set  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (r_op == OP_WR) begin
                    w_ram_we   = 1'b1;
                    w_ack_set  = 1'b1;
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                w_capture  = 1'b1;
                w_ack_set  = 1'b1;
                w_state_nx = DONE;
                if (r_op == OP_TAS) begin
                    w_ram_we = 1'b1;
                    w_ram_d  = 1'b1;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_gnt      <= GNT_S;
            r_op       <= OP_RD;
            r_addr     <= '0;
            r_di       <= 1'b0;
            r_last_cpu <= 1'b1;
            r_ack_s    <= 1'b0;
            r_ack_0    <= 1'b0;
            r_ack_1    <= 1'b0;
            r_dq_s     <= 1'b0;
            r_dq_0     <= 1'b0;
            r_dq_1     <= 1'b0;
        end else begin
            r_ack_s <= w_ack_set && (r_gnt == GNT_S);
            r_ack_0 <= w_ack_set && (r_gnt == GNT_0);
            r_ack_1 <= w_ack_set && (r_gnt == GNT_1);
            if ((r_state == IDLE) && w_any) begin
                r_gnt  <= w_win;
                r_op   <= w_win_op;
                r_addr <= w_win_addr;
                r_di   <= w_win_di;
                if (w_win != GNT_S) begin
                    r_last_cpu <= (w_win == GNT_1);
                end
            end
            if (w_capture) begin
                case (r_gnt)
                    GNT_S:   r_dq_s <= w_ram_q;
                    GNT_0:   r_dq_0 <= w_ram_q;
                    GNT_1:   r_dq_1 <= w_ram_q;
                    default: r_dq_s <= r_dq_s;
                endcase
            end
        end
    end

    sem_bit_ram #(
        .AW (AW)
    ) u_ram (
        .clk    (CLK),
        .i_addr (r_addr),
        .i_we   (w_ram_we),
        .i_d    (w_ram_d),
        .o_q    (w_ram_q)
    );

    assign WT_S = w_req_s & ~r_ack_s;
    assign WT_0 = w_req_0 & ~r_ack_0;
    assign WT_1 = w_req_1 & ~r_ack_1;
    assign DQ_S = r_dq_s;
    assign DQ_0 = r_dq_0;
    assign DQ_1 = r_dq_1;
    assign BUSY = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sem_bit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sem_bit_arbiter
// Brief    : Directed and randomized bench with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_sem_bit_arbiter;

    logic        CLK;
    logic        CLR;
    logic [11:0] A_S, A_0, A_1;
    logic        DI_S, WE_S, OE_S, DQ_S, WT_S;
    logic        DI_0, WE_0, OE_0, LK_0, DQ_0, WT_0;
    logic        DI_1, WE_1, OE_1, LK_1, DQ_1, WT_1;
    logic        BUSY;

    sem_bit_arbiter #(.AW(12)) dut (
        .CLK(CLK), .CLR(CLR),
        .A_S(A_S), .DI_S(DI_S), .WE_S(WE_S), .OE_S(OE_S), .DQ_S(DQ_S), .WT_S(WT_S),
        .A_0(A_0), .DI_0(DI_0), .WE_0(WE_0), .OE_0(OE_0), .LK_0(LK_0), .DQ_0(DQ_0), .WT_0(WT_0),
        .A_1(A_1), .DI_1(DI_1), .WE_1(WE_1), .OE_1(OE_1), .LK_1(LK_1), .DQ_1(DQ_1), .WT_1(WT_1),
        .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic        oe;
        logic        lk;
        logic [11:0] addr;
        logic        di;
        int          dly;
    } op_t;

    // Port index: 0 = S, 1 = CPU0, 2 = CPU1.
    op_t  prog [3][64];
    int   head [3];
    int   tail [3];
    int   waited [3];
    bit   active [3];
    op_t  cur [3];
    logic last_dq [3];
    bit   mem_m [4096];
    int   cyc, free_at, busy_from, done_at, gnt_p, last_cpu;
    logic exp_q;
    int   n_cmp, n_bad;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int p, input logic we, input logic oe, input logic lk,
                        input logic [11:0] a, input logic di, input int dly);
        prog[p][tail[p]] = '{we: we, oe: oe, lk: lk, addr: a, di: di, dly: dly};
        tail[p]++;
    endtask

    task automatic model_reset();
        last_cpu  = 2;
        free_at   = 0;
        busy_from = 1;
        done_at   = 0;
        gnt_p     = -1;
        for (int p = 0; p < 3; p++) last_dq[p] = 1'b0;
    endtask

    function automatic bit pending();
        for (int p = 0; p < 3; p++) begin
            if (active[p] || head[p] < tail[p]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive();
        A_S  = active[0] ? cur[0].addr : 12'h0;
        DI_S = active[0] && cur[0].di;
        WE_S = active[0] && cur[0].we;
        OE_S = active[0] && cur[0].oe;
        A_0  = active[1] ? cur[1].addr : 12'h0;
        DI_0 = active[1] && cur[1].di;
        WE_0 = active[1] && cur[1].we;
        OE_0 = active[1] && cur[1].oe;
        LK_0 = active[1] && cur[1].lk;
        A_1  = active[2] ? cur[2].addr : 12'h0;
        DI_1 = active[2] && cur[2].di;
        WE_1 = active[2] && cur[2].we;
        OE_1 = active[2] && cur[2].oe;
        LK_1 = active[2] && cur[2].lk;
    endtask

    // Transaction model: one access at a time, S first, CPUs alternate on ties.
    task automatic model_grant();
        int w;
        int dur;
        w = -1;
        if (cyc < free_at) return;
        if (active[0]) w = 0;
        else if (active[1] && active[2]) w = (last_cpu == 2) ? 1 : 2;
        else if (active[1]) w = 1;
        else if (active[2]) w = 2;
        if (w < 0) return;
        if (w > 0) last_cpu = w;
        if (cur[w].we) begin
            mem_m[cur[w].addr] = cur[w].di;
            dur = 2;
        end else begin
            exp_q = mem_m[cur[w].addr];
            if (cur[w].lk) mem_m[cur[w].addr] = 1'b1;
            dur = 3;
        end
        gnt_p     = w;
        busy_from = cyc + 1;
        done_at   = cyc + dur;
        free_at   = done_at + 1;
    endtask

    function automatic logic wt_obs(input int p);
        case (p)
            0:       return WT_S;
            1:       return WT_0;
            default: return WT_1;
        endcase
    endfunction

    function automatic logic dq_obs(input int p);
        case (p)
            0:       return DQ_S;
            1:       return DQ_0;
            default: return DQ_1;
        endcase
    endfunction

    task automatic check_cycle();
        bit fin;
        check("busy", BUSY, (cyc >= busy_from) && (cyc <= done_at));
        for (int p = 0; p < 3; p++) begin
            fin = active[p] && (gnt_p == p) && (done_at == cyc);
            if (fin && !cur[p].we) last_dq[p] = exp_q;
            check($sformatf("wt%0d", p), wt_obs(p), active[p] && !fin);
            check($sformatf("dq%0d", p), dq_obs(p), last_dq[p]);
            if (fin) begin
                active[p] = 1'b0;
                head[p]++;
            end
        end
    endtask

    task automatic run_engine(input int max_cyc);
        int n;
        n = 0;
        while (pending() && n < max_cyc) begin
            @(posedge CLK);
            #1;
            cyc++;
            for (int p = 0; p < 3; p++) begin
                if (!active[p] && head[p] < tail[p]) begin
                    if (waited[p] < prog[p][head[p]].dly) begin
                        waited[p]++;
                    end else begin
                        cur[p]    = prog[p][head[p]];
                        active[p] = 1'b1;
                        waited[p] = 0;
                    end
                end
            end
            drive();
            model_grant();
            @(negedge CLK);
            check_cycle();
            n++;
        end
        check("engine_done", !pending(), 1'b1);
        @(posedge CLK);
        #1;
        cyc++;
        drive();
        @(negedge CLK);
        check_cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        for (int p = 0; p < 3; p++) begin
            head[p] = 0; tail[p] = 0; waited[p] = 0; active[p] = 1'b0;
        end
        model_reset();
        CLR = 1'b0;
        drive();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", BUSY, 1'b0);
        check("rst_dq_s", DQ_S, 1'b0);
        check("rst_dq_0", DQ_0, 1'b0);
        check("rst_dq_1", DQ_1, 1'b0);
        check("rst_wt_s", WT_S, 1'b0);
        check("rst_wt_0", WT_0, 1'b0);
        check("rst_wt_1", WT_1, 1'b0);
        CLR = 1'b1;

        // Tie right after reset, then CPU0 re-requests while CPU1 waits.
        push(1, 1, 0, 0, 12'h040, 1, 0);
        push(2, 1, 0, 0, 12'h041, 0, 0);
        push(1, 1, 0, 0, 12'h040, 0, 0);
        push(2, 1, 0, 0, 12'h041, 1, 0);
        run_engine(100);

        // Write then read back on CPU0.
        push(1, 1, 0, 0, 12'h005, 1, 0);
        push(1, 0, 1, 0, 12'h005, 0, 0);
        run_engine(100);
        check("t1_rd", DQ_0, 1'b1);

        // S beats both CPUs; S returns mid-CPU-access and goes next.
        push(0, 1, 0, 0, 12'h050, 1, 0);
        push(1, 0, 1, 0, 12'h050, 0, 0);
        push(2, 0, 1, 0, 12'h050, 0, 0);
        push(0, 1, 0, 0, 12'h051, 0, 3);
        run_engine(100);

        // Sequential test-and-set on 0x010.
        push(0, 1, 0, 0, 12'h010, 0, 0);
        run_engine(100);
        push(1, 0, 1, 1, 12'h010, 0, 0);
        run_engine(100);
        check("t4_tas0", DQ_0, 1'b0);
        push(2, 0, 1, 1, 12'h010, 0, 0);
        run_engine(100);
        check("t4_tas1", DQ_1, 1'b1);
        push(0, 0, 1, 0, 12'h010, 0, 0);
        run_engine(100);
        check("t4_bit", DQ_S, 1'b1);

        // Competing test-and-set: exactly one winner.
        push(0, 1, 0, 0, 12'h020, 0, 0);
        run_engine(100);
        push(1, 0, 1, 1, 12'h020, 0, 0);
        push(2, 0, 1, 1, 12'h020, 0, 0);
        run_engine(100);
        check("t5_one_zero", DQ_0 ^ DQ_1, 1'b1);

        // Randomized mix on a small, pre-initialised address window.
        for (int i = 0; i < 8; i++) push(0, 1, 0, 0, 12'h100 + 12'(i), 1'($urandom_range(0, 1)), 0);
        push(0, 1, 0, 0, 12'h030, 0, 0);
        run_engine(200);
        for (int i = 0; i < 20; i++) begin
            for (int p = 0; p < 3; p++) begin
                int   k;
                logic we, oe, lk;
                k  = $urandom_range(0, 3);
                we = (k == 0) || (k == 3);
                oe = (k != 0);
                lk = (p > 0) && ((k == 2) || (k == 0 && $urandom_range(0, 1) == 1));
                push(p, we, oe, lk, 12'h100 + 12'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end
        end
        run_engine(3000);

        // Reset during CAPTURE of a test-and-set on 0x030.
        @(posedge CLK);
        #1;
        A_0 = 12'h030; WE_0 = 1'b0; OE_0 = 1'b1; LK_0 = 1'b1; DI_0 = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("t6_busy_capture", BUSY, 1'b1);
        CLR  = 1'b0;
        OE_0 = 1'b0;
        LK_0 = 1'b0;
        #1;
        check("t6_busy", BUSY, 1'b0);
        check("t6_dq_s", DQ_S, 1'b0);
        check("t6_dq_0", DQ_0, 1'b0);
        check("t6_dq_1", DQ_1, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b1;
        model_reset();
        push(2, 0, 1, 0, 12'h030, 0, 0);
        push(1, 0, 1, 0, 12'h030, 0, 0);
        run_engine(100);
        check("t6_bit_kept", DQ_1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
